// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the ram_dp_bwe dual-port RAM.
//   clr_state_e        - clear sequencer state (CLEAR, RUN)
//   merge_write_first  - byte-merges write data over stored data by lane enable
//   addr_in_range      - true when an address selects an existing word
// Helpers work on the widest supported word (MAX_BYTES lanes); callers
// zero-extend their operands and truncate the result to their own width.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;

  localparam int MAX_BYTES = 16;
  localparam int MAX_DW    = 8 * MAX_BYTES;

  // Written lanes take the new byte, the others keep the stored byte.
  function automatic logic [MAX_DW-1:0] merge_write_first(
    input logic [MAX_DW-1:0]    stored,
    input logic [MAX_DW-1:0]    wdata,
    input logic [MAX_BYTES-1:0] we
  );
    logic [MAX_DW-1:0] merged;
    merged = stored;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (we[b]) begin
        merged[8*b +: 8] = wdata[8*b +: 8];
      end
    end
    return merged;
  endfunction

  // WORDS need not be a power of two, so the top address codes may be empty.
  function automatic logic addr_in_range(
    input logic [31:0] addr,
    input logic [31:0] words
  );
    return addr < words;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: post-reset zero-fill sequencer and READY generator.
//   clk, rst    - clock and synchronous active-high reset
//   ready       - registered; high once the array may be accessed
//   clear_we    - high while a zero word is being written
//   clear_addr  - word being zeroed this cycle
// After reset the FSM walks every word once (CLEAR), then parks in RUN.
// READY is registered off the state, so it rises one edge after RUN is
// entered: WORDS+1 edges after reset release when clearing, one edge
// otherwise.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int WORDS          = 128,
  parameter int AW             = 7,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  output logic          clear_we,
  output logic [AW-1:0] clear_addr
);

  clr_state_e    state_reg, state_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic          ready_reg, ready_next;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= ready_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == CLEAR) begin
      if (cnt_reg == AW'(WORDS - 1)) begin
        state_next = RUN;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Output logic.
  always_comb begin
    clear_we   = (state_reg == CLEAR);
    clear_addr = cnt_reg;
    ready_next = (state_reg == RUN);
  end

  assign ready = ready_reg;

endmodule

// File: rtl/ram_dp_bwe.sv
// ram_dp_bwe: behavioural dual-port RAM, WORDS x (8*BYTES).
//   CLK, RST            - clock, synchronous active-high reset
//   VPWR, VGND          - power pins, no functional effect
//   EN0, WE0, A0, Di0   - port 0 read/write access with byte-write enables
//   Do0                 - port 0 read data (write-first)
//   EN1, A1, Do1        - port 1 read-only access (read-first on collision)
//   READY               - ports accept accesses
//   COLL                - one-cycle pulse after a port 0 write / port 1 read
//                         of the same in-range address
// OUT_REG=1 adds a second read stage that only loads when stage 1 loaded on
// the previous edge, so an idle port keeps presenting its last data.
module ram_dp_bwe
  import ram_pkg::*;
#(
  parameter  int WORDS          = 128,
  parameter  int BYTES          = 4,
  parameter  int OUT_REG        = 0,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int AW             = $clog2(WORDS),
  localparam int DW             = 8 * BYTES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VPWR,
  input  logic             VGND,
  input  logic             EN0,
  input  logic [BYTES-1:0] WE0,
  input  logic [AW-1:0]    A0,
  input  logic [DW-1:0]    Di0,
  output logic [DW-1:0]    Do0,
  input  logic             EN1,
  input  logic [AW-1:0]    A1,
  output logic [DW-1:0]    Do1,
  output logic             READY,
  output logic             COLL
);

  logic unused_pins;
  assign unused_pins = VPWR ^ VGND;

  // Clear sequencer.
  logic          ready;
  logic          clear_we;
  logic [AW-1:0] clear_addr;

  ram_clear_seq #(
    .WORDS          (WORDS),
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk        (CLK),
    .rst        (RST),
    .ready      (ready),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  assign READY = ready;

  // Access qualification: nothing reaches the array until READY.
  logic a0_ok, a1_ok;
  logic acc0, acc1, wr0;

  assign a0_ok = addr_in_range(32'(A0), 32'(WORDS));
  assign a1_ok = addr_in_range(32'(A1), 32'(WORDS));
  assign acc0  = ready & EN0;
  assign acc1  = ready & EN1;
  assign wr0   = acc0 & (|WE0) & a0_ok;

  // Single write port: the clear sequencer owns it before READY, port 0 after.
  logic [BYTES-1:0] mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane_we
    assign mem_we[gi] = clear_we | (wr0 & WE0[gi]);
  end

  assign mem_addr  = clear_we ? clear_addr : A0;
  assign mem_wdata = clear_we ? '0 : Di0;

  // Storage array; contents are deliberately not reset.
  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge CLK) begin
    for (int b = 0; b < BYTES; b++) begin
      if (mem_we[b]) begin
        mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Read data: port 0 sees its own write this edge, port 1 sees old contents.
  logic [DW-1:0] rd0_raw, rd1_raw, merged0;

  assign rd0_raw = mem[A0];
  assign rd1_raw = mem[A1];
  assign merged0 = DW'(merge_write_first(MAX_DW'(rd0_raw), MAX_DW'(Di0),
                                         MAX_BYTES'(WE0)));

  // Stage 1 read registers and the collision flag.
  logic [DW-1:0] d0_s1, d1_s1;
  logic          coll_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      d0_s1    <= '0;
      d1_s1    <= '0;
      coll_reg <= 1'b0;
    end else begin
      if (acc0) begin
        d0_s1 <= a0_ok ? merged0 : '0;
      end
      if (acc1) begin
        d1_s1 <= a1_ok ? rd1_raw : '0;
      end
      // An out-of-range write is dropped, so it cannot collide.
      coll_reg <= wr0 & acc1 & (A0 == A1);
    end
  end

  assign COLL = coll_reg;

  // Optional stage 2.
  if (OUT_REG != 0) begin : g_out_reg
    logic          v0_s1, v1_s1;
    logic [DW-1:0] d0_s2, d1_s2;

    always_ff @(posedge CLK) begin
      if (RST) begin
        v0_s1 <= 1'b0;
        v1_s1 <= 1'b0;
        d0_s2 <= '0;
        d1_s2 <= '0;
      end else begin
        v0_s1 <= acc0;
        v1_s1 <= acc1;
        if (v0_s1) begin
          d0_s2 <= d0_s1;
        end
        if (v1_s1) begin
          d1_s2 <= d1_s1;
        end
      end
    end

    assign Do0 = d0_s2;
    assign Do1 = d1_s2;
  end else begin : g_no_out_reg
    assign Do0 = d0_s1;
    assign Do1 = d1_s1;
  end

endmodule
